// File: rtl/wb_queue.sv
// wb_queue: writeback queue in front of the general register file write port.
// Results enter through a valid/ready handshake and sit in a DEPTH-entry FIFO.
// The FIFO drains one entry per cycle whenever the write port is free.
// Decode can read the youngest pending value for each read address from the fwd outputs.
// Optional build macro WB_QUEUE_FLUSH_EN adds a synchronous flush input.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_num,
  input  logic [31:0]   in_data,
  input  logic          port_free,
  output logic          reg_wr,
  output logic [4:0]    wr_num,
  output logic [31:0]   wr_data,
  input  logic [4:0]    read1,
  input  logic [4:0]    read2,
  output logic          fwd1_hit,
  output logic [31:0]   fwd1_data,
  output logic          fwd2_hit,
  output logic [31:0]   fwd2_data,
  output logic [AW:0]   count
`ifdef WB_QUEUE_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [4:0]       num_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [AW:0]      count_q;

  logic flush_req;
  logic push;
  logic pop;

`ifdef WB_QUEUE_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Full is judged from the count, so a full queue never accepts even while it pops.
  assign in_ready = (count_q != FULL_COUNT);
  assign count    = count_q;

  // Register 0 is hardwired, so a push to it completes the handshake but stores nothing.
  assign push   = in_valid && in_ready && (in_num != 5'd0) && !flush_req;
  assign reg_wr = (count_q != '0) && port_free && !flush_req;
  assign pop    = reg_wr;

  assign wr_num  = num_q[head_q];
  assign wr_data = data_q[head_q];

  // Scan from head (oldest) to tail so later matches overwrite earlier ones; the youngest wins.
  always_comb begin
    logic [AW-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (valid_q[idx] && (read1 != 5'd0) && (num_q[idx] == read1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_q[idx];
      end
      if (valid_q[idx] && (read2 != 5'd0) && (num_q[idx] == read2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_q[idx];
      end
    end
  end

  // FIFO storage, pointers and occupancy; flush outranks both push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        num_q[i]  <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_req) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        num_q[tail_q]   <= in_num;
        data_q[tail_q]  <= in_data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + AW'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed bench for wb_queue with hand-computed expectations.
// Define WB_QUEUE_FLUSH_EN for both files to also exercise the flush input.
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_num;
  logic [31:0] in_data;
  logic        port_free;
  logic        reg_wr;
  logic [4:0]  wr_num;
  logic [31:0] wr_data;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
`ifdef WB_QUEUE_FLUSH_EN
  logic        flush;
`endif

  int vectors;
  int miscompares;

  wb_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_data   (in_data),
    .port_free (port_free),
    .reg_wr    (reg_wr),
    .wr_num    (wr_num),
    .wr_data   (wr_data),
    .read1     (read1),
    .read2     (read2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count)
`ifdef WB_QUEUE_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the producer and port inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] num, input logic [31:0] data, input logic free);
    in_valid  = v;
    in_num    = num;
    in_data   = data;
    port_free = free;
    #1;
  endtask

  // Advance past the next rising edge, well clear of it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    read1 = 5'd5;
    read2 = 5'd0;
`ifdef WB_QUEUE_FLUSH_EN
    flush = 1'b0;
`endif
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    tick();

    // Reset state
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_reg_wr",   32'(reg_wr),   32'd0);
    checkOutput("rst_count",    32'(count),    32'd0);
    checkOutput("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    checkOutput("rst_fwd2_hit", 32'(fwd2_hit), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_reg_wr", 32'(reg_wr), 32'd0);

    // Single push, drained on the next edge
    applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("p1_reg_wr",    32'(reg_wr),   32'd1);
    checkOutput("p1_wr_num",    32'(wr_num),   32'd5);
    checkOutput("p1_wr_data",   wr_data,       32'h12345678);
    checkOutput("p1_count",     32'(count),    32'd1);
    checkOutput("p1_fwd1_hit",  32'(fwd1_hit), 32'd1);
    checkOutput("p1_fwd1_data", fwd1_data,     32'h12345678);
    tick();
    checkOutput("p1_count_after", 32'(count),  32'd0);
    checkOutput("p1_reg_wr_after", 32'(reg_wr), 32'd0);

    // Fill with the write port blocked
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'(k), 32'hA0 + 32'(k), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("full_count",    32'(count),    32'd4);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_reg_wr",   32'(reg_wr),   32'd0);
    applyStimulus(1'b1, 5'd9, 32'hA5, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("full_reject_count", 32'(count),    32'd4);
    checkOutput("full_pop_in_ready", 32'(in_ready), 32'd0);

    // Drain in order, one per cycle
    for (int k = 1; k <= 4; k++) begin
      checkOutput("drain_reg_wr",  32'(reg_wr), 32'd1);
      checkOutput("drain_wr_num",  32'(wr_num), 32'(k));
      checkOutput("drain_wr_data", wr_data,     32'hA0 + 32'(k));
      tick();
      checkOutput("drain_in_ready", 32'(in_ready), 32'd1);
      checkOutput("drain_count",    32'(count),    32'(4 - k));
    end
    checkOutput("drain_done_reg_wr", 32'(reg_wr), 32'd0);

    // Forwarding picks the youngest of two writes to the same register
    applyStimulus(1'b1, 5'd7, 32'h11, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h22, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
    read1 = 5'd7;
    read2 = 5'd0;
    #1;
    checkOutput("fwd_hit1",  32'(fwd1_hit), 32'd1);
    checkOutput("fwd_data1", fwd1_data,     32'h22);
    checkOutput("fwd_hit2",  32'(fwd2_hit), 32'd0);
    checkOutput("fwd_data2", fwd2_data,     32'h0);
    read2 = 5'd3;
    #1;
    checkOutput("fwd_miss_hit2", 32'(fwd2_hit), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("fwd_head_data", wr_data,       32'h11);
    checkOutput("fwd_head_hit",  32'(fwd1_hit), 32'd1);
    tick();
    checkOutput("fwd_one_left_count", 32'(count), 32'd1);
    checkOutput("fwd_one_left_data",  fwd1_data,   32'h22);
    checkOutput("fwd_one_left_wr",    wr_data,     32'h22);
    tick();
    checkOutput("fwd_empty_hit",  32'(fwd1_hit), 32'd0);
    checkOutput("fwd_empty_data", fwd1_data,     32'h0);

    // Push to r0 completes the handshake but stores nothing
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b1);
    checkOutput("r0_in_ready", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("r0_count",  32'(count),  32'd0);
    checkOutput("r0_reg_wr", 32'(reg_wr), 32'd0);

    // Steady push/pop across the pointer wrap
    applyStimulus(1'b1, 5'd10, 32'hB0, 1'b0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 5'(10 + k), 32'hB0 + 32'(k), 1'b1);
      checkOutput("wrap_wr_num",  32'(wr_num), 32'(10 + k - 1));
      checkOutput("wrap_wr_data", wr_data,     32'hB0 + 32'(k - 1));
      tick();
      checkOutput("wrap_count", 32'(count), 32'd1);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("wrap_last_num", 32'(wr_num), 32'd20);
    tick();
    checkOutput("wrap_empty_count", 32'(count), 32'd0);

    // Asynchronous reset in the middle of a drain
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 5'(k + 20), 32'hC0 + 32'(k), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("mid_count",  32'(count),  32'd3);
    checkOutput("mid_reg_wr", 32'(reg_wr), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_count",    32'(count),    32'd0);
    checkOutput("mid_rst_reg_wr",   32'(reg_wr),   32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_count", 32'(count), 32'd0);

`ifdef WB_QUEUE_FLUSH_EN
    // Flush beats a simultaneous push and pop
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 5'(k), 32'hD0 + 32'(k), 1'b0);
      tick();
    end
    checkOutput("fl_count_before", 32'(count), 32'd3);
    read1 = 5'd9;
    flush = 1'b1;
    applyStimulus(1'b1, 5'd9, 32'hEE, 1'b1);
    checkOutput("fl_reg_wr", 32'(reg_wr), 32'd0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("fl_count",    32'(count),    32'd0);
    checkOutput("fl_reg_wr2",  32'(reg_wr),   32'd0);
    checkOutput("fl_fwd_hit",  32'(fwd1_hit), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
